// File: rtl/synth_pkg.sv
// Purpose: shared constants, state type and saturation helper for the synth monitor path.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: CLK_HZ_DEFAULT, FREQ_W/FREQ_MAX output scale, det_state_t, sat_freq().
package synth_pkg;

    localparam int CLK_HZ_DEFAULT = 1000000;
    localparam int FREQ_W         = 12;
    localparam int FREQ_MAX       = 4095;

    typedef enum logic {
        SEEK,
        MEASURE
    } det_state_t;

    // Clamp a full-width quotient onto the oscillator frequency scale.
    function automatic logic [FREQ_W-1:0] sat_freq(input logic [31:0] q);
        if (q > 32'(FREQ_MAX)) begin
            return FREQ_W'(FREQ_MAX);
        end
        return q[FREQ_W-1:0];
    endfunction

endpackage

// File: rtl/seq_div32.sv
// Purpose: 32/32 unsigned restoring divider, one quotient bit per cycle.
// Latency: start accepted on edge S, done pulses after edge S+32 with quotient valid and held.
// Backpressure: start while busy is ignored; rst aborts any division in flight.
// Ports: clk, rst (sync, active high), start, dividend, divisor -> busy, done, quotient.
module seq_div32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [32:0] shifted;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Partial remainder with the next dividend bit shifted in; the
        // dividend register doubles as the quotient shift register.
        shifted = {rem_q, quo_q[31]};
        if (busy_q) begin
            if (shifted >= {1'b0, dsr_q}) begin
                rem_d = 32'(shifted - {1'b0, dsr_q});
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dsr_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/osc_freq_detect.sv
// Purpose: pitch detector; Schmitt-triggered period measurement averaged over 2^AVG_LOG2 periods, reported in Hz.
// Latency: window-closing crossing accepted on edge E0 -> freq/freq_valid at edge E0+34.
// Backpressure: none on samples; a window closing while the divider is busy is dropped silently.
// Ports: clk, rst, sample[15:0] signed, sample_valid -> freq[11:0], freq_valid (pulse), locked.
module osc_freq_detect
    import synth_pkg::*;
#(
    parameter int                 CLK_HZ   = CLK_HZ_DEFAULT,
    parameter logic signed [15:0] HYST     = 16'sd256,
    parameter int                 AVG_LOG2 = 2,
    parameter int                 MIN_HZ   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       sample,
    input  logic                     sample_valid,
    output logic [FREQ_W-1:0]        freq,
    output logic                     freq_valid,
    output logic                     locked
);

    localparam logic [31:0]        DIVIDEND     = 32'(CLK_HZ) << AVG_LOG2;
    // Timeout fires on the edge where per_cnt would reach CLK_HZ/MIN_HZ.
    localparam logic [31:0]        TIMEOUT_LAST = 32'(CLK_HZ / MIN_HZ - 1);
    localparam logic signed [15:0] NEG_HYST     = -HYST;
    localparam int                 WIN          = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0]  WIN_K        = WIN[AVG_LOG2:0];
    localparam logic [AVG_LOG2:0]  K_ONE        = (AVG_LOG2 + 1)'(1);

    logic                 pos_q, pos_d;
    logic                 cross_q;
    det_state_t           state_q, state_d;
    logic [31:0]          per_cnt_q, per_cnt_d;
    logic [31:0]          sum_q, sum_d, new_sum;
    logic [AVG_LOG2:0]    k_q, k_d, k_inc;
    logic [FREQ_W-1:0]    freq_q, freq_d;
    logic                 fv_q, fv_d;
    logic                 locked_q, locked_d;
    logic                 timeout;
    logic                 div_start, div_abort, div_busy, div_done;
    logic [31:0]          div_quot;

    // Schmitt trigger; holds between thresholds and on unaccepted cycles.
    always_comb begin
        pos_d = pos_q;
        if (sample_valid) begin
            if (sample >= HYST) begin
                pos_d = 1'b1;
            end else if (sample <= NEG_HYST) begin
                pos_d = 1'b0;
            end
        end
    end

    assign timeout   = (state_q == MEASURE) && (per_cnt_q >= TIMEOUT_LAST);
    assign div_abort = rst | timeout;
    // per_cnt holds (period - 1) when the crossing is acted on.
    assign new_sum   = sum_q + per_cnt_q + 32'd1;
    assign k_inc     = k_q + K_ONE;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q + 32'd1;
        sum_d      = sum_q;
        k_d        = k_q;
        freq_d     = freq_q;
        fv_d       = 1'b0;
        locked_d   = locked_q;
        div_start  = 1'b0;
        case (state_q)
            SEEK: begin
                if (cross_q) begin
                    per_cnt_d = '0;
                    sum_d     = '0;
                    k_d       = '0;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    // Takes priority over a crossing acted on this cycle.
                    state_d = SEEK;
                    freq_d  = '0;
                    if (locked_q) begin
                        locked_d = 1'b0;
                        fv_d     = 1'b1;
                    end
                end else begin
                    if (cross_q) begin
                        per_cnt_d = '0;
                        if (k_inc == WIN_K) begin
                            // Closing crossing also opens the next window.
                            sum_d     = '0;
                            k_d       = '0;
                            div_start = !div_busy;
                        end else begin
                            sum_d = new_sum;
                            k_d   = k_inc;
                        end
                    end
                    if (div_done) begin
                        freq_d   = sat_freq(div_quot);
                        fv_d     = 1'b1;
                        locked_d = 1'b1;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= 1'b0;
            cross_q   <= 1'b0;
            state_q   <= SEEK;
            per_cnt_q <= '0;
            sum_q     <= '0;
            k_q       <= '0;
            freq_q    <= '0;
            fv_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            cross_q   <= pos_d & ~pos_q;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            sum_q     <= sum_d;
            k_q       <= k_d;
            freq_q    <= freq_d;
            fv_q      <= fv_d;
            locked_q  <= locked_d;
        end
    end

    seq_div32 u_div (
        .clk      (clk),
        .rst      (div_abort),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (new_sum),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign freq       = freq_q;
    assign freq_valid = fv_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_osc_freq_detect.sv
// Purpose: self-checking bench for osc_freq_detect; scoreboard of expected freq_valid pulses.
// Latency: expected pulses are scheduled by a bench-side Schmitt/window model at crossing edge + 34.
// Backpressure: n/a.
module tb_osc_freq_detect;

    localparam int AMP      = 2048;
    localparam int DIVIDEND = 4000000;
    localparam int TO_EDGES = 50001;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic [11:0]        freq;
    logic               freq_valid;
    logic               locked;

    typedef struct {
        int   cyc;
        int   fq;
        logic lk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    logic mon_exp_now;

    // Bench-side model state
    logic m_pos, m_seek, m_locked, m_close_seen;
    int   m_open, m_k, m_last, m_close;

    osc_freq_detect dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .freq         (freq),
        .freq_valid   (freq_valid),
        .locked       (locked)
    );

    initial forever #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    // Drives one cycle, advances to the accepting edge, updates the model, returns 1 time unit later.
    task automatic drive_cycle(input int s, input logic v, input logic r);
        logic np;
        int   sum;
        int   q;
        sample       = 16'(s);
        sample_valid = v;
        rst          = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_seek   = 1'b1;
            m_pos    = 1'b0;
            m_locked = 1'b0;
            while (exp_q.size() > 0 && exp_q[$].cyc >= edge_n) void'(exp_q.pop_back());
        end else begin
            // Timeout: 50000 cycles after the crossing is acted on (one edge after acceptance).
            if (!m_seek && edge_n == m_last + TO_EDGES) begin
                m_seek = 1'b1;
                if (m_locked) exp_q.push_back('{edge_n, 0, 1'b0});
                m_locked = 1'b0;
            end
            np = m_pos;
            if (v && s >= 256) np = 1'b1;
            else if (v && s <= -256) np = 1'b0;
            if (np && !m_pos) begin
                if (m_seek) begin
                    m_seek = 1'b0;
                    m_open = edge_n;
                    m_k    = 0;
                end else begin
                    m_k++;
                    if (m_k == 4) begin
                        sum = edge_n - m_open;
                        q   = DIVIDEND / sum;
                        exp_q.push_back('{edge_n + 34, (q > 4095) ? 4095 : q, 1'b1});
                        m_locked     = 1'b1;
                        m_open       = edge_n;
                        m_k          = 0;
                        m_close      = edge_n;
                        m_close_seen = 1'b1;
                    end
                end
                m_last = edge_n;
            end
            m_pos = np;
        end
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk_eq({tag, "_freq"}, {20'd0, freq}, 32'd0);
        chk_eq({tag, "_fv"}, {31'd0, freq_valid}, 32'd0);
        chk_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive_cycle(0, 1'b0, 1'b1);
    endtask

    // Square wave: low half first, then n full periods (high then low).
    task automatic square(input int half, input int n);
        repeat (half) drive_cycle(-AMP, 1'b1, 1'b0);
        repeat (n) begin
            repeat (half) drive_cycle(AMP, 1'b1, 1'b0);
            repeat (half) drive_cycle(-AMP, 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (edge_n > 0) begin
            mon_exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == edge_n);
            if (freq_valid !== 1'b0 || mon_exp_now) begin
                chk_eq("freq_valid", {31'd0, freq_valid}, {31'd0, mon_exp_now});
                if (mon_exp_now) begin
                    chk_eq("pulse_freq", {20'd0, freq}, 32'(exp_q[0].fq));
                    chk_eq("pulse_locked", {31'd0, locked}, {31'd0, exp_q[0].lk});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int s;
        m_pos = 1'b0; m_seek = 1'b1; m_locked = 1'b0; m_close_seen = 1'b0;
        m_open = 0; m_k = 0; m_last = 0; m_close = 0;
        rst = 1'b1; sample = '0; sample_valid = 1'b0;

        // Reset state
        do_reset(2);
        check_idle("reset");

        // 440 Hz square, period 2272
        square(1136, 5);
        chk_eq("sq440_q_empty", 32'(exp_q.size()), 32'd0);
        chk_eq("sq440_freq", {20'd0, freq}, 32'd440);
        chk_eq("sq440_locked", {31'd0, locked}, 32'd1);
        do_reset(2);
        check_idle("sq440_rst");

        // Saw at 440 Hz, sample_valid 1 in 4; unaccepted cycles carry the inverted sample.
        for (int t = 0; t < 5 * 2272 + 200; t++) begin
            s = -4095 + (8190 * (t % 2272)) / 2272;
            drive_cycle((t % 4 == 0) ? s : -s, (t % 4 == 0), 1'b0);
        end
        chk_eq("saw_q_empty", 32'(exp_q.size()), 32'd0);
        chk_eq("saw_freq_in_range", {31'd0, (freq >= 12'd439 && freq <= 12'd441)}, 32'd1);
        chk_eq("saw_locked", {31'd0, locked}, 32'd1);
        do_reset(2);

        // Hysteresis: +/-0x00F0 toggling every cycle
        for (int t = 0; t < 1000; t++) drive_cycle((t % 2 == 0) ? 240 : -240, 1'b1, 1'b0);
        check_idle("hyst");
        chk_eq("hyst_q_empty", 32'(exp_q.size()), 32'd0);

        // Saturation: period 200 -> 5000 Hz clamps to 4095
        square(100, 12);
        chk_eq("sat_q_empty", 32'(exp_q.size()), 32'd0);
        chk_eq("sat_freq", {20'd0, freq}, 32'd4095);
        do_reset(2);

        // Reset mid-divide: rst for one cycle at E0+10
        m_close_seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (m_close_seen && edge_n == m_close + 9) break;
            drive_cycle(((t / 100) % 2 == 1) ? AMP : -AMP, 1'b1, 1'b0);
        end
        chk_eq("rmd_window_closed", {31'd0, m_close_seen}, 32'd1);
        drive_cycle(0, 1'b1, 1'b1);
        check_idle("rmd");
        repeat (60) drive_cycle(0, 1'b1, 1'b0);
        chk_eq("rmd_q_empty", 32'(exp_q.size()), 32'd0);
        check_idle("rmd_after");

        // Loss of signal: lock on 1 kHz, then hold 0
        square(500, 5);
        chk_eq("los_freq_1k", {20'd0, freq}, 32'd1000);
        chk_eq("los_locked_1k", {31'd0, locked}, 32'd1);
        repeat (50100) drive_cycle(0, 1'b1, 1'b0);
        chk_eq("los_q_empty", 32'(exp_q.size()), 32'd0);
        check_idle("los");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
